// File: rtl/comparator_pkg.sv
// Shared constants for the bit-serial comparator: FSM encoding and default operand width.
// No logic here; constants only.
// Imported by comparator_serial.
package comparator_pkg;

    localparam int CMP_WIDTH = 32;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SCAN = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = S_IDLE,
        ST_SCAN = S_SCAN,
        ST_DONE = S_DONE
    } state_e;

endpackage

// File: rtl/cmp_bit_cell.sv
// Single-bit compare cell: flags a differing bit pair and which side wins.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module cmp_bit_cell (
    input  logic a_bit,
    input  logic b_bit,
    input  logic msb,
    input  logic is_signed,
    output logic differ,
    output logic a_greater
);

    assign differ = a_bit ^ b_bit;

    // The sign bit of a two's-complement operand carries negative weight, so a set bit there loses.
    assign a_greater = (msb && is_signed) ? b_bit : a_bit;

endmodule

// File: rtl/comparator_serial.sv
// Bit-serial MSB-first signed/unsigned comparator with start/done handshake and registered gt/lt/eq flags.
// Latency: 1..WIDTH cycles from accept to done, exiting on the first differing bit.
// Backpressure: start is ignored while scanning; a start in the done cycle is accepted back-to-back.
module comparator_serial
    import comparator_pkg::*;
#(
    parameter int WIDTH = CMP_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             is_signed,
    output logic             busy,
    output logic             done,
    output logic             out_gt,
    output logic             out_lt,
    output logic             out_eq
);

    localparam int            IW      = $clog2(WIDTH);
    localparam logic [IW-1:0] IDX_TOP = IW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             sgn_q, sgn_d;
    logic             gt_q, gt_d;
    logic             lt_q, lt_d;
    logic             eq_q, eq_d;

    logic bit_differ;
    logic bit_a_gt;
    logic decide;
    logic accept;

    cmp_bit_cell u_cell (
        .a_bit     (a_q[idx_q]),
        .b_bit     (b_q[idx_q]),
        .msb       (idx_q == IDX_TOP),
        .is_signed (sgn_q),
        .differ    (bit_differ),
        .a_greater (bit_a_gt)
    );

    assign decide = bit_differ || (idx_q == '0);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        sgn_d   = sgn_q;
        gt_d    = gt_q;
        lt_d    = lt_q;
        eq_d    = eq_q;
        accept  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                accept = start;
            end
            ST_SCAN: begin
                if (bit_differ) begin
                    gt_d    = bit_a_gt;
                    lt_d    = ~bit_a_gt;
                    state_d = ST_DONE;
                end else if (idx_q == '0) begin
                    eq_d    = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q - 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                accept  = start;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (accept) begin
            a_d     = a;
            b_d     = b;
            sgn_d   = is_signed;
            idx_d   = IDX_TOP;
            gt_d    = 1'b0;
            lt_d    = 1'b0;
            eq_d    = 1'b0;
            state_d = ST_SCAN;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= IDX_TOP;
            a_q     <= '0;
            b_q     <= '0;
            sgn_q   <= 1'b0;
            gt_q    <= 1'b0;
            lt_q    <= 1'b0;
            eq_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sgn_q   <= sgn_d;
            gt_q    <= gt_d;
            lt_q    <= lt_d;
            eq_q    <= eq_d;
        end
    end

    // busy drops in the deciding cycle, so it is high for one cycle less than the compare latency.
    assign busy   = (state_q == ST_SCAN) && !decide;
    assign done   = (state_q == ST_DONE);
    assign out_gt = gt_q;
    assign out_lt = lt_q;
    assign out_eq = eq_q;

endmodule

// File: tb/tb_comparator_serial.sv
// Scoreboard bench for comparator_serial: directed vectors push expected flags/latency, a negedge monitor checks each done pulse.
module tb_comparator_serial;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        is_signed;
    logic        busy;
    logic        done;
    logic        out_gt;
    logic        out_lt;
    logic        out_eq;

    comparator_serial #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .a         (a),
        .b         (b),
        .is_signed (is_signed),
        .busy      (busy),
        .done      (done),
        .out_gt    (out_gt),
        .out_lt    (out_lt),
        .out_eq    (out_eq)
    );

    typedef struct {
        logic [2:0] flags;
        int         done_cyc;
        int         lat;
        string      name;
    } exp_t;

    exp_t q[$];
    int   cyc      = 0;
    int   n_total  = 0;
    int   n_pass   = 0;
    int   busy_cnt = 0;
    int   n_push   = 0;
    int   n_done   = 0;

    localparam logic [2:0] GT = 3'b100;
    localparam logic [2:0] LT = 3'b010;
    localparam logic [2:0] EQ = 3'b001;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int expv);
        n_total++;
        if (act == expv) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    endtask

    // Monitor: checks flags stay clear while scanning and scores every done pulse.
    always @(negedge clk) begin
        if (!rst_n) begin
            busy_cnt = 0;
        end else begin
            if (busy) begin
                busy_cnt++;
                chk("flags_clear_in_scan", int'({out_gt, out_lt, out_eq}), 0);
            end
            if (done) begin
                n_done++;
                if (q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk({e.name, "_flags"}, int'({out_gt, out_lt, out_eq}), int'(e.flags));
                    chk({e.name, "_done_cycle"}, cyc, e.done_cyc);
                    chk({e.name, "_busy_cycles"}, busy_cnt, e.lat - 1);
                end
                busy_cnt = 0;
            end
        end
    end

    // Called at a negedge just after start/operands are driven: the accepting edge is cyc+1.
    task automatic push_exp(input logic [2:0] f, input int lat, input string nm);
        exp_t e;
        e.flags    = f;
        e.lat      = lat;
        e.done_cyc = cyc + 1 + lat;
        e.name     = nm;
        q.push_back(e);
        n_push++;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            chk("timeout_waiting_for_done", 1, 0);
            q.delete();
        end
    endtask

    task automatic do_cmp(input logic [31:0] va, input logic [31:0] vb, input logic s,
                          input logic [2:0] f, input int lat, input string nm);
        @(negedge clk);
        start = 1'b1; a = va; b = vb; is_signed = s;
        push_exp(f, lat, nm);
        @(negedge clk);
        start = 1'b0;
        wait_idle();
    endtask

    // Back-to-back chain: start held high, junk operands during SCAN, real operands in the DONE cycle.
    logic [31:0] ca   [4];
    logic [31:0] cb   [4];
    logic        cs   [4];
    logic [2:0]  cf   [4];
    int          clat [4];

    initial begin
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; is_signed = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_flags", int'({out_gt, out_lt, out_eq}), 0);
        rst_n = 1'b1;

        do_cmp(32'd12, 32'd12, 1'b1, EQ, 32, "eq_12");
        do_cmp(32'd17, 32'd22, 1'b1, LT, 30, "s17_22");
        do_cmp(32'd3,  32'd1,  1'b1, GT, 31, "s3_1");
        do_cmp(-32'sd3, 32'd1, 1'b1, LT, 1,  "s_m3_1");
        do_cmp(-32'sd3, 32'd1, 1'b0, GT, 1,  "u_m3_1");
        do_cmp(-32'sd17, -32'sd22, 1'b1, GT, 30, "s_m17_m22");
        do_cmp(32'd3, -32'sd1, 1'b1, GT, 1,  "s3_m1");
        do_cmp(32'h8000_0000, 32'h7FFF_FFFF, 1'b0, GT, 1, "u_msb");
        do_cmp(32'h8000_0000, 32'h7FFF_FFFF, 1'b1, LT, 1, "s_msb");
        do_cmp(32'd0, 32'd1, 1'b0, LT, 32, "u_bit0");

        ca[0] = 32'h8000_0000; cb[0] = 32'h0000_0000; cs[0] = 1'b0; cf[0] = GT; clat[0] = 1;
        ca[1] = 32'h4000_0000; cb[1] = 32'h6000_0000; cs[1] = 1'b0; cf[1] = LT; clat[1] = 3;
        ca[2] = 32'd5;         cb[2] = 32'd5;         cs[2] = 1'b1; cf[2] = EQ; clat[2] = 32;
        ca[3] = 32'h7FFF_FFFF; cb[3] = 32'hFFFF_FFFF; cs[3] = 1'b1; cf[3] = GT; clat[3] = 1;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge clk);
            start = 1'b1; a = ca[k]; b = cb[k]; is_signed = cs[k];
            push_exp(cf[k], clat[k], "b2b");
            for (int j = 1; j <= clat[k]; j++) begin
                @(negedge clk);
                a = 32'(j * 7); b = ~32'(j * 7); is_signed = j[0];
            end
        end
        @(negedge clk);
        start = 1'b0;
        wait_idle();

        // Abort a 32-cycle compare with reset sampled at E5.
        @(negedge clk);
        start = 1'b1; a = 32'd12; b = 32'd12; is_signed = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_flags", int'({out_gt, out_lt, out_eq}), 0);
        rst_n = 1'b1;
        do_cmp(32'd5, 32'd5, 1'b0, EQ, 32, "after_abort");

        repeat (3) @(negedge clk);
        chk("pending_expectations", q.size(), 0);
        chk("done_pulse_count", n_done, n_push);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
